// File: rtl/reprog_pkg.sv
// Shared definitions for the reprogrammable boot/program RAM:
// frame sync byte, receiver state encoding and address-field sizing.
package reprog_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        COUNT,
        DATA,
        CSUM
    } state_t;

    // Number of stream bytes carrying an ADDR or COUNT field.
    function automatic int addrBytes(input int aw);
        return (aw + 7) / 8;
    endfunction

endpackage

// File: rtl/reprog_frame_rx.sv
// Frame receiver: parses SYNC/ADDR/COUNT/DATA/CSUM byte stream and issues
// full-word writes on the port-B override bus as each word completes.
//
// state | meaning
// IDLE  | waiting for SYNC byte, other bytes discarded
// ADDR  | shifting in start word address, LSB first
// COUNT | shifting in word count minus one, LSB first
// DATA  | assembling words; each completed word is written immediately
// CSUM  | waiting for checksum byte; done pulse or sticky error
module reprog_frame_rx
    import reprog_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    prog_en,
    input  logic [7:0]              prog_data,
    input  logic                    prog_valid,
    output logic                    prog_ready,
    output logic                    prog_busy,
    output logic                    prog_done,
    output logic                    prog_error,
    output logic [ADDR_WIDTH-1:0]   ovr_addr,
    output logic [8*DATA_BYTES-1:0] ovr_data,
    output logic                    ovr_we
);
    localparam int AB  = addrBytes(ADDR_WIDTH);
    localparam int AW8 = AB * 8;
    localparam int W   = 8 * DATA_BYTES;

    state_t                  state, state_nxt;
    logic [7:0]              bcnt;
    logic [AW8-1:0]          shift;
    logic [W-1:0]            word;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic [7:0]              csum;

    logic                    fire;
    logic [AW8+7:0]          shift_full;
    logic [AW8-1:0]          shift_nxt;
    logic [W+7:0]            word_full;
    logic [W-1:0]            word_nxt;
    logic                    last_ab;
    logic                    last_db;
    logic [7:0]              csum_nxt;

    assign fire       = prog_valid & prog_ready & prog_en;
    assign shift_full = {prog_data, shift};
    assign shift_nxt  = shift_full[AW8+7:8];
    assign word_full  = {prog_data, word};
    assign word_nxt   = word_full[W+7:8];
    assign last_ab    = (bcnt == 8'(AB - 1));
    assign last_db    = (bcnt == 8'(DATA_BYTES - 1));
    assign csum_nxt   = csum + prog_data;

    assign prog_busy  = (state != IDLE);
    assign ovr_addr   = ptr;
    assign ovr_data   = word_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ovr_we    = 1'b0;
        if (!prog_en) begin
            state_nxt = IDLE;
        end else if (fire) begin
            case (state)
                IDLE:  if (prog_data == SYNC_BYTE) state_nxt = ADDR;
                ADDR:  if (last_ab) state_nxt = COUNT;
                COUNT: if (last_ab) state_nxt = DATA;
                DATA: begin
                    if (last_db) begin
                        ovr_we = 1'b1;
                        if (remaining == '0) state_nxt = CSUM;
                    end
                end
                CSUM:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
            prog_error <= 1'b0;
            bcnt       <= '0;
            shift      <= '0;
            word       <= '0;
            ptr        <= '0;
            remaining  <= '0;
            csum       <= '0;
        end else begin
            prog_ready <= prog_en;
            prog_done  <= 1'b0;
            if (!prog_en) begin
                // Losing the engine mid-frame is an abort.
                if (state != IDLE) prog_error <= 1'b1;
                bcnt <= '0;
            end else if (fire) begin
                case (state)
                    IDLE: begin
                        if (prog_data == SYNC_BYTE) begin
                            prog_error <= 1'b0;
                            csum       <= '0;
                            bcnt       <= '0;
                        end
                    end
                    ADDR, COUNT: begin
                        shift <= shift_nxt;
                        csum  <= csum_nxt;
                        if (last_ab) begin
                            bcnt <= '0;
                            if (state == ADDR) ptr       <= shift_nxt[ADDR_WIDTH-1:0];
                            else               remaining <= shift_nxt[ADDR_WIDTH-1:0];
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end
                    DATA: begin
                        word <= word_nxt;
                        csum <= csum_nxt;
                        if (last_db) begin
                            bcnt      <= '0;
                            ptr       <= ptr + 1'b1;
                            remaining <= remaining - 1'b1;
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end
                    CSUM: begin
                        if (csum_nxt == 8'h00) prog_done  <= 1'b1;
                        else                   prog_error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/reprog_mem.sv
// True-dual-port read-first RAM with a stream reprogramming engine that
// takes over port B while progEn is high.
module reprog_mem
    import reprog_pkg::*;
#(
    parameter int    ADDR_WIDTH = 12,
    parameter int    DATA_BYTES = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   addra,
    input  logic [8*DATA_BYTES-1:0] dina,
    input  logic [DATA_BYTES-1:0]   wea,
    input  logic                    ena,
    output logic [8*DATA_BYTES-1:0] douta,
    input  logic [ADDR_WIDTH-1:0]   addrb,
    input  logic [8*DATA_BYTES-1:0] dinb,
    input  logic [DATA_BYTES-1:0]   web,
    input  logic                    enb,
    output logic [8*DATA_BYTES-1:0] doutb,
    input  logic                    progEn,
    input  logic [7:0]              progData,
    input  logic                    progValid,
    output logic                    progReady,
    output logic                    progBusy,
    output logic                    progDone,
    output logic                    progError
);
    localparam int W     = 8 * DATA_BYTES;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [W-1:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   ovr_addr;
    logic [W-1:0]            ovr_data;
    logic                    ovr_we;
    logic [ADDR_WIDTH-1:0]   addr_b_eff;
    logic [W-1:0]            din_b_eff;
    logic [DATA_BYTES-1:0]   we_a_eff;
    logic [DATA_BYTES-1:0]   we_b_eff;

    reprog_frame_rx #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_BYTES (DATA_BYTES)
    ) u_rx (
        .clk        (clk),
        .rstn       (rstn),
        .prog_en    (progEn),
        .prog_data  (progData),
        .prog_valid (progValid),
        .prog_ready (progReady),
        .prog_busy  (progBusy),
        .prog_done  (progDone),
        .prog_error (progError),
        .ovr_addr   (ovr_addr),
        .ovr_data   (ovr_data),
        .ovr_we     (ovr_we)
    );

    assign addr_b_eff = progEn ? ovr_addr : addrb;
    assign din_b_eff  = progEn ? ovr_data : dinb;
    assign we_b_eff   = progEn ? {DATA_BYTES{ovr_we}} : (enb ? web : '0);
    assign we_a_eff   = ena ? wea : '0;

    // Port B lanes are applied last so they win a same-address collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (we_a_eff[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
        end
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (we_b_eff[i]) mem[addr_b_eff][i*8 +: 8] <= din_b_eff[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    douta <= '0;
        else if (ena) douta <= mem[addra];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                doutb <= '0;
        else if (!progEn && enb)  doutb <= mem[addrb];
    end

endmodule
